inst_fetch: RTL

- Instruction-fetch initiator that drives the synchronous instruction ROM port, one word per cycle.
- Owns the fetch PC and tracks the one-cycle ROM read latency.
- Buffers the returned word while the decode stage stalls, and redirects on branch/jump flush.
- Sits between the ROM and the IF/ID boundary of the core.

---
 rtl/inst_fetch_if.sv | 39 +++
 rtl/inst_fetch.sv | 103 ++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Bundles the instruction-fetch signals: the synchronous ROM read port, the
// downstream stall / flush controls and the IF/ID output triple.
//   rom_re_o    ROM read enable            (fetch unit -> ROM)
//   rom_addr_o  ROM word address           (fetch unit -> ROM)
//   rom_inst_i  ROM read data, 1-cycle lat (ROM -> fetch unit)
//   stall_i     decode cannot accept       (core -> fetch unit)
//   flush_i     redirect request           (core -> fetch unit)
//   flush_pc_i  redirect target            (core -> fetch unit)
//   valid_o     output carries live instr  (fetch unit -> decode)
//   inst_o      fetched instruction        (fetch unit -> decode)
//   pc_o        address of inst_o          (fetch unit -> decode)
// Modport master is the fetch unit, slave is its environment.
// ---------------------------------------------------------------------------
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              rom_re_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_inst_i;
    logic              stall_i;
    logic              flush_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic              valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;

    modport master (
        output rom_re_o, rom_addr_o, valid_o, inst_o, pc_o,
        input  rom_inst_i, stall_i, flush_i, flush_pc_i
    );

    modport slave (
        input  rom_re_o, rom_addr_o, valid_o, inst_o, pc_o,
        output rom_inst_i, stall_i, flush_i, flush_pc_i
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch initiator in front of a synchronous (1-cycle latency)
// instruction ROM. Issues one word address per cycle, tracks the in-flight
// read, parks the returned word in a skid register while decode stalls, and
// redirects immediately on flush.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     inst_fetch_if.master (ROM port, stall/flush, valid/inst/pc)
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    inst_fetch_if.master  bus
);

    logic [ADDR_W-1:0] pc_r;        // next sequential fetch address
    logic              req_vld_r;   // a ROM read was issued last cycle
    logic [ADDR_W-1:0] req_pc_r;    // address of that read
    logic              hold_r;      // HOLD mode: skid register is live
    logic [INST_W-1:0] hold_inst_r;
    logic [ADDR_W-1:0] hold_pc_r;

    logic              valid_s;
    logic [INST_W-1:0] inst_s;
    logic [ADDR_W-1:0] pc_s;
    logic              issue_s;
    logic              capture_s;
    logic [ADDR_W-1:0] addr_s;

    // Output select: the skid register wins; otherwise the ROM data of the
    // in-flight read is passed straight through.
    always_comb begin
        valid_s = 1'b0;
        inst_s  = {INST_W{1'b0}};
        pc_s    = {ADDR_W{1'b0}};
        if (hold_r) begin
            valid_s = 1'b1;
            inst_s  = hold_inst_r;
            pc_s    = hold_pc_r;
        end else if (req_vld_r) begin
            valid_s = 1'b1;
            inst_s  = bus.rom_inst_i;
            pc_s    = req_pc_r;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Issue decision and address mux. A flush always issues; otherwise we
    // issue unless a live instruction is being stalled. The ROM clears its
    // data when not read, so a stalled word in RUN mode must be captured.
    always_comb begin
        issue_s   = bus.flush_i | ~(valid_s & bus.stall_i);
        capture_s = ~hold_r & valid_s & bus.stall_i & ~bus.flush_i;
        addr_s    = pc_r;
        if (bus.flush_i) begin
            addr_s = {bus.flush_pc_i[ADDR_W-1:2], 2'b00};
        end else begin
            addr_s = pc_r;
        end
    end

    // Read enable is forced low while reset is asserted; state is already
    // cleared asynchronously so the outputs below fall to zero as well.
    assign bus.rom_re_o   = issue_s & rst_ni;
    assign bus.rom_addr_o = addr_s;
    assign bus.valid_o    = valid_s;
    assign bus.inst_o     = inst_s;
    assign bus.pc_o       = pc_s;

    // Fetch state: every issue starts a new read and leaves HOLD (an issue
    // in HOLD means either the held word was accepted or a flush hit);
    // a stalled live word in RUN is moved into the skid register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r        <= RESET_PC;
            req_vld_r   <= 1'b0;
            req_pc_r    <= {ADDR_W{1'b0}};
            hold_r      <= 1'b0;
            hold_inst_r <= {INST_W{1'b0}};
            hold_pc_r   <= {ADDR_W{1'b0}};
        end else if (issue_s) begin
            req_vld_r   <= 1'b1;
            req_pc_r    <= addr_s;
            pc_r        <= addr_s + ADDR_W'(4);
            hold_r      <= 1'b0;
        end else if (capture_s) begin
            hold_r      <= 1'b1;
            hold_inst_r <= bus.rom_inst_i;
            hold_pc_r   <= req_pc_r;
            req_vld_r   <= 1'b0;
        end else begin
            hold_r      <= hold_r;
        end
    end

endmodule
